// File: rtl/alu_pkg.sv
// Shared op-code constants, FSM state encoding and op-code width for the ALU.
package alu_pkg;

    localparam int unsigned OPW = 4;

    localparam logic [OPW-1:0] OP_AND  = 4'b0000;
    localparam logic [OPW-1:0] OP_OR   = 4'b0001;
    localparam logic [OPW-1:0] OP_ADD  = 4'b0010;
    localparam logic [OPW-1:0] OP_XOR  = 4'b0011;
    localparam logic [OPW-1:0] OP_SUB  = 4'b0110;
    localparam logic [OPW-1:0] OP_SLT  = 4'b0111;
    localparam logic [OPW-1:0] OP_SLTU = 4'b1000;
    localparam logic [OPW-1:0] OP_SLL  = 4'b1001;
    localparam logic [OPW-1:0] OP_SRL  = 4'b1010;
    localparam logic [OPW-1:0] OP_SRA  = 4'b1011;
    localparam logic [OPW-1:0] OP_MUL  = 4'b1100;
    localparam logic [OPW-1:0] OP_DIVU = 4'b1101;
    localparam logic [OPW-1:0] OP_REMU = 4'b1110;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_MUL  = 2'b01,
        S_DIV  = 2'b10
    } state_t;

endpackage

// File: rtl/seq_divider.sv
// Restoring unsigned divider, one quotient bit per step. quotient/remainder
// show the values after the current step so the caller can capture them on
// the edge where last is high. A zero divisor naturally yields all-ones
// quotient and remainder equal to the dividend.
module seq_divider #(
    parameter int unsigned XLEN = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            step,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder,
    output logic            last
);

    localparam int unsigned CW = $clog2(XLEN);

    logic [XLEN-1:0] quo;
    logic [XLEN-1:0] rem;
    logic [XLEN-1:0] dsr;
    logic [CW-1:0]   cnt;
    logic [XLEN:0]   rem_sh;
    logic            fits;

    // Trial subtraction of the divisor from the shifted partial remainder.
    always_comb begin
        rem_sh    = {rem, quo[XLEN-1]};
        fits      = rem_sh >= {1'b0, dsr};
        remainder = fits ? XLEN'(rem_sh - {1'b0, dsr}) : rem_sh[XLEN-1:0];
        quotient  = {quo[XLEN-2:0], fits};
        last      = cnt == CW'(XLEN - 1);
    end

    // Load operands on acceptance, then advance one bit per step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quo <= '0;
            rem <= '0;
            dsr <= '0;
            cnt <= '0;
        end else if (load) begin
            quo <= dividend;
            rem <= '0;
            dsr <= divisor;
            cnt <= '0;
        end else if (step) begin
            quo <= quotient;
            rem <= remainder;
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/multicycle_alu.sv
// ALU with single-cycle logic/arith ops and iterative MUL/DIVU/REMU.
module multicycle_alu
    import alu_pkg::*;
#(
    parameter int unsigned XLEN = 64,
    parameter int unsigned OPW  = alu_pkg::OPW
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            flush,
    input  logic [OPW-1:0]  op,
    input  logic [XLEN-1:0] x,
    input  logic [XLEN-1:0] y,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic            cout,
    output logic            zero,
    output logic            illegal
);

    localparam int unsigned SHW = $clog2(XLEN);

    state_t          state, state_nx;
    logic            is_mul, is_div, is_rem;
    logic            div_last;
    logic [XLEN-1:0] div_q, div_r;
    logic [XLEN-1:0] mcand, mplier, acc, acc_next;
    logic [SHW-1:0]  mcnt;
    logic            mul_last;
    logic [XLEN:0]   add_w, sub_w;
    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] sc_result;
    logic            sc_cout, sc_illegal;

    assign busy = state != S_IDLE;
    assign zero = result == '0;

    // Single-cycle datapath plus op classification.
    always_comb begin
        sc_result  = '0;
        sc_cout    = 1'b0;
        sc_illegal = 1'b0;
        add_w      = {1'b0, x} + {1'b0, y};
        sub_w      = {1'b0, x} - {1'b0, y};
        shamt      = y[SHW-1:0];
        is_mul     = op == OP_MUL;
        is_div     = (op == OP_DIVU) || (op == OP_REMU);
        case (op)
            OP_ADD:  begin sc_result = add_w[XLEN-1:0]; sc_cout = add_w[XLEN]; end
            OP_SUB:  begin sc_result = sub_w[XLEN-1:0]; sc_cout = sub_w[XLEN]; end
            OP_AND:  sc_result = x & y;
            OP_OR:   sc_result = x | y;
            OP_XOR:  sc_result = x ^ y;
            OP_SLT:  sc_result = {{(XLEN-1){1'b0}}, $signed(x) < $signed(y)};
            OP_SLTU: sc_result = {{(XLEN-1){1'b0}}, x < y};
            OP_SLL:  sc_result = x << shamt;
            OP_SRL:  sc_result = x >> shamt;
            OP_SRA:  sc_result = $signed(x) >>> shamt;
            OP_MUL, OP_DIVU, OP_REMU: sc_result = '0;
            default: sc_illegal = 1'b1;
        endcase
    end

    // Shift-add multiplier step.
    always_comb begin
        acc_next = acc + (mplier[0] ? mcand : '0);
        mul_last = mcnt == SHW'(XLEN - 1);
    end

    seq_divider #(
        .XLEN(XLEN)
    ) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (state == S_IDLE && start && is_div),
        .step     (state == S_DIV && !flush),
        .dividend (x),
        .divisor  (y),
        .quotient (div_q),
        .remainder(div_r),
        .last     (div_last)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    // Next-state: flush wins over completion in the busy states.
    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: if (start) begin
                if (is_mul)      state_nx = S_MUL;
                else if (is_div) state_nx = S_DIV;
            end
            S_MUL:   if (flush || mul_last) state_nx = S_IDLE;
            S_DIV:   if (flush || div_last) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Result registers, multiplier iteration and done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result  <= '0;
            cout    <= 1'b0;
            illegal <= 1'b0;
            done    <= 1'b0;
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            mcnt    <= '0;
            is_rem  <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: if (start) begin
                    is_rem <= op == OP_REMU;
                    if (is_mul) begin
                        mcand  <= x;
                        mplier <= y;
                        acc    <= '0;
                        mcnt   <= '0;
                    end else if (!is_div) begin
                        result  <= sc_result;
                        cout    <= sc_cout;
                        illegal <= sc_illegal;
                        done    <= 1'b1;
                    end
                end
                S_MUL: if (!flush) begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    mcnt   <= mcnt + SHW'(1);
                    if (mul_last) begin
                        result  <= acc_next;
                        cout    <= 1'b0;
                        illegal <= 1'b0;
                        done    <= 1'b1;
                    end
                end
                S_DIV: if (!flush && div_last) begin
                    result  <= is_rem ? div_r : div_q;
                    cout    <= 1'b0;
                    illegal <= 1'b0;
                    done    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/multicycle_alu.md
MULTICYCLE_ALU -- requirements
Module: multicycle_alu

Interface
REQ-001 Parameter XLEN, default 64; operand/result width; legal values 32 and 64.
REQ-002 Parameter OPW, default 4; width of the operation code.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 start  input  1  request; accepted only when busy=0.
REQ-006 flush  input  1  cancel an in-flight iterative operation.
REQ-007 op  input  OPW  operation code, sampled with start.
REQ-008 x, y  input  XLEN each  operands, sampled with start.
REQ-009 busy  output  1  iterative operation in progress.
REQ-010 done  output  1  one-cycle pulse; result, cout, zero and illegal valid.
REQ-011 result  output  XLEN  registered result, held until the next completion.
REQ-012 cout  output  1  carry/borrow of the last ADD/SUB.
REQ-013 zero  output  1  result == 0, combinational from the result register.
REQ-014 illegal  output  1  last completed op code was unassigned.

Function
REQ-015 Op codes SHALL be: 0010 ADD, 0110 SUB, 0000 AND, 0001 OR, 0011 XOR, 0111 SLT, 1000 SLTU, 1001 SLL, 1010 SRL, 1011 SRA, 1100 MUL (low XLEN bits), 1101 DIVU, 1110 REMU.
REQ-016 States SHALL be IDLE, MUL, DIV; busy=1 exactly in MUL and DIV.
REQ-017 A single-cycle op accepted at edge E0 SHALL update result and pulse done in the cycle after E0; state stays IDLE.
REQ-018 MUL/DIVU/REMU accepted at E0 SHALL enter MUL or DIV, iterate one bit per edge (shift-add / restoring), and return to IDLE at edge E_XLEN, where result updates and done pulses for one cycle.
REQ-019 start with busy=1 SHALL be ignored without side effects; start in the cycle done is high SHALL be accepted (back-to-back).
REQ-020 ADD/SUB SHALL compute in XLEN+1 bits; cout = bit XLEN (SUB: 1 when y > x unsigned); every other op SHALL write cout=0.
REQ-021 Shift amount SHALL be y[log2(XLEN)-1:0]; SRA sign-extends x.
REQ-022 SLT/SLTU SHALL return 1 or 0 zero-extended to XLEN, signed/unsigned compare respectively.
REQ-023 DIVU by zero SHALL return all ones; REMU by zero SHALL return x; latency unchanged.
REQ-024 Unassigned op SHALL complete as single-cycle with result=0, cout=0, illegal=1; legal ops write illegal=0.
REQ-025 flush while busy SHALL return to IDLE at the next edge, leave result/cout/illegal unchanged, and suppress done; flush in IDLE SHALL have no effect.
REQ-026 flush and start in the same IDLE cycle: start SHALL be accepted.
REQ-027 Operands SHALL be internally latched at acceptance; x, y, op changes while busy SHALL not affect the result.

Reset
REQ-028 rst_n low SHALL force, without a clock, state=IDLE, busy=0, done=0, result=0, cout=0, illegal=0, and therefore zero=1.
REQ-029 Reset during MUL/DIV SHALL abandon the operation with no done pulse; the first edge after release accepts start normally.

Structure
REQ-030 Package alu_pkg SHALL hold the op-code constants, the state enumeration and OPW.
REQ-031 The restoring divider datapath (quotient/remainder registers, XLEN-cycle counter) SHALL be the sub-module seq_divider; the multiplier iterates in the top level.

Verification (XLEN=64)
REQ-032 ADD x=FFFF_FFFF_FFFF_FFFF, y=1 -> result=0, cout=1, zero=1, done one cycle after start.
REQ-033 SUB x=3, y=5 -> result=FFFF_FFFF_FFFF_FFFE, cout=1; SLT x=-1, y=1 -> 1; SLTU same operands -> 0.
REQ-034 MUL x=0x1_0000_0001, y=0x1_0000_0001 -> result=0x2_0000_0001, done exactly 64 cycles after acceptance, busy high for those 64 cycles.
REQ-035 DIVU x=100, y=7 -> 14; REMU -> 2; DIVU y=0 -> all ones; REMU x=9, y=0 -> 9.
REQ-036 MUL started, flush at cycle 10 -> no done, result keeps prior value, next ADD 2+2 -> 4 one cycle later.
REQ-037 rst_n low at cycle 30 of DIVU -> busy=0, result=0, zero=1 immediately; op=1111 -> illegal=1, result=0.
